// File: rtl/csa_pretreat_param.sv
// csa_pretreat_param
//
// Purpose:
//   Front end of the CSA scrambling path. It collects one framed job from a
//   33-bit word stream (a parameter header followed by N TS packets), checks
//   it, buffers the payload, and replays it as a gap-free sequence of byte
//   strobes: packet count, PID number, GbE number, IP/port bytes, control
//   word bytes (skipped when the control word is all zero) and finally the
//   TS payload bytes. It then waits for the encryptor to report completion
//   before accepting the next frame.
//
// Parameters:
//   MAX_PKT    maximum TS packets per frame (1..255)
//   GBE_CH     number of valid GbE channel numbers (0..GBE_CH-1)
//   PKT_WORDS  32-bit words per TS packet (47 for 188 bytes)
//
// Ports:
//   clk_main         clock
//   rst              asynchronous active-high reset
//   ts_din[32:0]     bit 32 = frame start flag, [31:0] = data word
//   ts_din_en        ts_din valid
//   ts_din_ready     block is accepting input words
//   finish_blk_enc   downstream encryption of the current frame is done
//   en_count_packet / count_packet   packet count strobe / value
//   en_pid_num / pid_num             PID number strobe / value
//   en_gbe_num / gbe_num             GbE number strobe / value
//   en_ip_port / ip_port             IP/port byte stream
//   en_cw_data / cw_data             control word byte stream
//   en_ts_dout / ts_dout             TS payload byte stream
//   err_frame        one-cycle pulse when a frame is rejected
//   err_ovf          one-cycle pulse per word dropped while not ready
module csa_pretreat_param #(
  parameter int MAX_PKT   = 8,
  parameter int GBE_CH    = 4,
  parameter int PKT_WORDS = 47
) (
  input  logic        clk_main,
  input  logic        rst,
  input  logic [32:0] ts_din,
  input  logic        ts_din_en,
  output logic        ts_din_ready,
  input  logic        finish_blk_enc,
  output logic        en_count_packet,
  output logic [7:0]  count_packet,
  output logic        en_pid_num,
  output logic [7:0]  pid_num,
  output logic        en_gbe_num,
  output logic [7:0]  gbe_num,
  output logic        en_ip_port,
  output logic [7:0]  ip_port,
  output logic        en_cw_data,
  output logic [7:0]  cw_data,
  output logic        en_ts_dout,
  output logic [7:0]  ts_dout,
  output logic        err_frame,
  output logic        err_ovf
);

  localparam int BUF_WORDS = MAX_PKT * PKT_WORDS;
  localparam int CNT_W     = $clog2(BUF_WORDS * 4) + 1;
  localparam int ADDR_W    = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

  localparam logic [7:0]       MAX_PKT_B = 8'(MAX_PKT);
  localparam logic [8:0]       GBE_CH_B  = 9'(GBE_CH);
  localparam logic [CNT_W-1:0] PKT_LAST  = CNT_W'(PKT_WORDS - 1);
  localparam logic [CNT_W-1:0] PKT_BYTES = CNT_W'(PKT_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DISCARD,
    OUT_PARAM,
    OUT_DATA,
    WAIT_FIN
  } state_t;

  state_t state, next_state;

  // Captured header fields
  logic [7:0]  n_pkt;
  logic [63:0] cw_reg;
  logic [7:0]  pid_reg;
  logic [7:0]  gbe_reg;
  logic [31:0] ip_reg;
  logic [2:0]  hdr_idx;

  // Buffer write side and replay counters
  logic [CNT_W-1:0] wr_addr;
  logic [CNT_W-1:0] pkt_word;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] last_word;
  logic [CNT_W-1:0] last_byte;
  logic [3:0]       out_idx;
  logic [3:0]       last_out_idx;

  logic accept;
  logic sof;
  logic hdr_bad;
  logic sync_bad;
  logic frame_err;

  logic [31:0] frame_buf [BUF_WORDS];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  // Input is only taken while collecting a frame; once the payload is complete
  // the block stays busy until the encryptor releases it.
  assign ts_din_ready = (state inside {IDLE, HDR, PAYLOAD, DISCARD});
  assign accept       = ts_din_en & ts_din_ready;
  assign sof          = ts_din[32];

  // Frame geometry derived from N; valid frames never exceed the counter range.
  assign last_word = CNT_W'(n_pkt) * CNT_W'(PKT_WORDS) - CNT_ONE;
  assign last_byte = CNT_W'(n_pkt) * PKT_BYTES - CNT_ONE;

  // The header check runs while W5 is presented, so gbe_reg already holds W4.
  assign hdr_bad  = (n_pkt == 8'd0) || (n_pkt > MAX_PKT_B) ||
                    ({1'b0, gbe_reg} >= GBE_CH_B);
  assign sync_bad = (pkt_word == '0) && (ts_din[31:24] != 8'h47);

  // An all-zero control word means clear mode: the parameter phase ends after
  // the last IP/port byte instead of the last control word byte.
  assign last_out_idx = (cw_reg == 64'h0) ? 4'd6 : 4'd14;

  assign rd_word = frame_buf[byte_cnt[ADDR_W+1:2]];

  // Payload bytes leave most significant byte first within each word.
  always_comb begin
    rd_byte = 8'h00;
    case (byte_cnt[1:0])
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Any accepted start-of-frame word while collecting
  // restarts the header with that word as W0; it is an error only when it
  // interrupts a frame already in progress.
  always_comb begin
    next_state = state;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && sof) begin
          next_state = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          if (sof) begin
            frame_err  = 1'b1;
            next_state = HDR;
          end else if (hdr_idx == 3'd5) begin
            if (hdr_bad) begin
              frame_err  = 1'b1;
              next_state = DISCARD;
            end else begin
              next_state = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (sof) begin
            frame_err  = 1'b1;
            next_state = HDR;
          end else if (sync_bad) begin
            frame_err  = 1'b1;
            next_state = DISCARD;
          end else if (wr_addr == last_word) begin
            next_state = OUT_PARAM;
          end
        end
      end
      DISCARD: begin
        if (accept && sof) begin
          next_state = HDR;
        end
      end
      OUT_PARAM: begin
        if (out_idx == last_out_idx) begin
          next_state = OUT_DATA;
        end
      end
      OUT_DATA: begin
        if (byte_cnt == last_byte) begin
          next_state = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (finish_blk_enc) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Header capture and counters. A start-of-frame word re-arms everything for
  // a fresh frame, so no state leaks from an aborted or rejected one.
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      n_pkt    <= 8'd0;
      cw_reg   <= 64'h0;
      pid_reg  <= 8'd0;
      gbe_reg  <= 8'd0;
      ip_reg   <= 32'h0;
      hdr_idx  <= 3'd0;
      wr_addr  <= '0;
      pkt_word <= '0;
      byte_cnt <= '0;
      out_idx  <= 4'd0;
    end else begin
      if (accept && sof) begin
        n_pkt    <= ts_din[7:0];
        hdr_idx  <= 3'd1;
        wr_addr  <= '0;
        pkt_word <= '0;
        byte_cnt <= '0;
        out_idx  <= 4'd0;
      end else if (accept && (state == HDR)) begin
        case (hdr_idx)
          3'd1:    cw_reg[63:32] <= ts_din[31:0];
          3'd2:    cw_reg[31:0]  <= ts_din[31:0];
          3'd3:    pid_reg       <= ts_din[7:0];
          3'd4:    gbe_reg       <= ts_din[7:0];
          3'd5:    ip_reg        <= ts_din[31:0];
          default: ;
        endcase
        hdr_idx <= hdr_idx + 3'd1;
      end else if (accept && (state == PAYLOAD)) begin
        wr_addr  <= wr_addr + CNT_ONE;
        pkt_word <= (pkt_word == PKT_LAST) ? '0 : pkt_word + CNT_ONE;
      end

      if (state == OUT_PARAM) begin
        out_idx <= out_idx + 4'd1;
      end
      if (state == OUT_DATA) begin
        byte_cnt <= byte_cnt + CNT_ONE;
      end
    end
  end

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk_main) begin
    if (accept && !sof && (state == PAYLOAD)) begin
      frame_buf[wr_addr[ADDR_W-1:0]] <= ts_din[31:0];
    end
  end

  // Output registers. Strobes default low each cycle while data registers
  // only change together with their strobe, so they hold their last value.
  always_ff @(posedge clk_main or posedge rst) begin
    if (rst) begin
      en_count_packet <= 1'b0;
      count_packet    <= 8'd0;
      en_pid_num      <= 1'b0;
      pid_num         <= 8'd0;
      en_gbe_num      <= 1'b0;
      gbe_num         <= 8'd0;
      en_ip_port      <= 1'b0;
      ip_port         <= 8'd0;
      en_cw_data      <= 1'b0;
      cw_data         <= 8'd0;
      en_ts_dout      <= 1'b0;
      ts_dout         <= 8'd0;
      err_frame       <= 1'b0;
      err_ovf         <= 1'b0;
    end else begin
      en_count_packet <= 1'b0;
      en_pid_num      <= 1'b0;
      en_gbe_num      <= 1'b0;
      en_ip_port      <= 1'b0;
      en_cw_data      <= 1'b0;
      en_ts_dout      <= 1'b0;
      err_frame       <= frame_err;
      err_ovf         <= ts_din_en & ~ts_din_ready;

      if (state == OUT_PARAM) begin
        case (out_idx)
          4'd0:  begin en_count_packet <= 1'b1; count_packet <= n_pkt;          end
          4'd1:  begin en_pid_num      <= 1'b1; pid_num      <= pid_reg;        end
          4'd2:  begin en_gbe_num      <= 1'b1; gbe_num      <= gbe_reg;        end
          4'd3:  begin en_ip_port      <= 1'b1; ip_port      <= ip_reg[31:24];  end
          4'd4:  begin en_ip_port      <= 1'b1; ip_port      <= ip_reg[23:16];  end
          4'd5:  begin en_ip_port      <= 1'b1; ip_port      <= ip_reg[15:8];   end
          4'd6:  begin en_ip_port      <= 1'b1; ip_port      <= ip_reg[7:0];    end
          4'd7:  begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[63:56];  end
          4'd8:  begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[55:48];  end
          4'd9:  begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[47:40];  end
          4'd10: begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[39:32];  end
          4'd11: begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[31:24];  end
          4'd12: begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[23:16];  end
          4'd13: begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[15:8];   end
          4'd14: begin en_cw_data      <= 1'b1; cw_data      <= cw_reg[7:0];    end
          default: ;
        endcase
      end

      if (state == OUT_DATA) begin
        en_ts_dout <= 1'b1;
        ts_dout    <= rd_byte;
      end
    end
  end

endmodule

// File: doc/csa_pretreat_param.md
CSA_PRETREAT_PARAM -- requirements
Module: csa_pretreat_param

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, meaning the maximum number of TS packets per frame (1..255).
REQ-002 SHALL have parameter GBE_CH, default 4, meaning the number of valid GbE channel numbers (0..GBE_CH-1).
REQ-003 SHALL have parameter PKT_WORDS, default 47, meaning the number of 32-bit words per 188-byte TS packet.
REQ-004 SHALL have one clock; reset is asynchronous and active-high, ports: clk_main input 1 (clock), rst input 1 (async active-high reset).
REQ-005 ts_din  input  33  bit32 = frame start flag, [31:0] = data word.
REQ-006 ts_din_en  input  1  ts_din valid.
REQ-007 ts_din_ready  output  1  block accepts a new frame.
REQ-008 finish_blk_enc  input  1  downstream encryption of the current frame is done.
REQ-009 en_count_packet/count_packet  output  1/8  packet-count strobe/value.
REQ-010 en_pid_num/pid_num, en_gbe_num/gbe_num  output  1/8 each  PID-number and GbE-number strobe/value.
REQ-011 en_ip_port/ip_port, en_cw_data/cw_data  output  1/8 each  IP/port byte stream, control-word byte stream.
REQ-012 en_ts_dout/ts_dout  output  1/8  TS payload byte stream.
REQ-013 err_frame  output  1  one-cycle pulse when a frame is rejected.
REQ-014 err_ovf  output  1  one-cycle pulse when a word is dropped while not ready.

Function
REQ-015 SHALL use this frame format, one word per ts_din_en cycle, with gaps allowed:
- W0: bit32=1, [7:0]=N.
- W1/W2: CW[63:32]/CW[31:0].
- W3: [7:0]=pid.
- W4: [7:0]=gbe.
- W5: 32-bit ip_port.
- Then N*PKT_WORDS payload words.
REQ-016 SHALL run an FSM with states IDLE, HDR, PAYLOAD, DISCARD, OUT_PARAM, OUT_DATA, WAIT_FIN.
REQ-017 IDLE: SHALL go to HDR on ts_din_en with bit32=1; words with bit32=0 SHALL be ignored silently.
REQ-018 HDR: SHALL capture W0..W5.
- Reject (err_frame pulse, go to DISCARD) when N=0, N>MAX_PKT, or gbe>=GBE_CH.
- Otherwise go to PAYLOAD after W5.
REQ-019 PAYLOAD: SHALL write words to an internal buffer of MAX_PKT*PKT_WORDS x 32 bits.
- The first word of each packet SHALL have [31:24]=8'h47; otherwise err_frame pulses and the FSM goes to DISCARD.
REQ-020 In HDR/PAYLOAD, a word with bit32=1 SHALL abort the frame, pulse err_frame, and restart HDR with that word taken as W0.
REQ-021 DISCARD: SHALL drop words until the next word with bit32=1, which starts HDR as W0.
REQ-022 After the last payload word is accepted, ts_din_ready SHALL go low on the next edge and the FSM SHALL go to OUT_PARAM.
REQ-023 OUT_PARAM SHALL emit one strobe per cycle with no gaps, in this order:
- count_packet=N;
- pid_num;
- gbe_num;
- 4 ip_port bytes, MSB first;
- 8 cw_data bytes, MSB first.
REQ-024 The first en_count_packet SHALL assert 2 cycles after the last payload word is accepted.
REQ-025 If CW==64'h0 (clear mode), the cw_data phase SHALL be skipped and en_cw_data SHALL stay low.
REQ-026 OUT_DATA SHALL follow OUT_PARAM in the next cycle and emit N*188 payload bytes, one per cycle, MSB first per word, with en_ts_dout high throughout.
REQ-027 WAIT_FIN SHALL hold all strobes low until finish_blk_enc=1.
- In that same cycle the FSM SHALL return to IDLE and ts_din_ready SHALL be 1 from the next cycle.
- finish_blk_enc SHALL be ignored in all other states.
REQ-028 Words presented while ts_din_ready=0 SHALL be dropped and SHALL pulse err_ovf, once per dropped word.
REQ-029 At most one en_* strobe SHALL be high in any cycle.
- Output data SHALL hold its last value when its strobe is low.
REQ-030 Buffer and byte counters SHALL be sized $clog2(MAX_PKT*PKT_WORDS*4)+1 bits, and wrap-around SHALL never occur within a valid frame.

Reset
REQ-031 On rst=1, the FSM SHALL enter IDLE asynchronously.
- All en_* strobes, err_frame, err_ovf and all output data SHALL be 0.
- ts_din_ready SHALL be 1.
- Buffer contents are don't-care.
REQ-032 Reset mid-frame or mid-output SHALL drop the frame with no further strobes.
- The first frame after reset release SHALL be processed normally.

Verification
REQ-033 Nominal: N=1, CW=64'h01234567_89abcdef, pid=8'h10, gbe=1, ip_port=32'hc0120801, payload 47400100 then bytes 1..184 -> expected response:
- count=1, pid=10, gbe=01;
- ip bytes c0,12,08,01;
- cw bytes 01..ef;
- 188 ts bytes 47,40,01,00,01,02..b8;
- idle until finish_blk_enc, then ts_din_ready=1.
REQ-034 Clear mode: same frame with CW=0 -> no en_cw_data; en_ts_dout starts on the cycle after the last ip_port byte.
REQ-035 Bad sync: second packet of an N=2 frame starts 8'h46 -> exactly one err_frame pulse, no output strobes; the next valid frame is processed normally.
REQ-036 Header reject: N=MAX_PKT+1 and, separately, gbe=GBE_CH -> err_frame pulse each time; the following frame is processed.
REQ-037 Overflow and restart:
- 3 words sent during OUT_DATA -> 3 err_ovf pulses and output unaffected.
- bit32=1 at payload word 10 -> err_frame pulse, and the new frame is captured correctly.
- rst asserted mid-OUT_DATA -> all outputs 0 immediately.
